// File: rtl/omni_slot_sched_if.sv
// omni_slot_sched_if: requester streams in, single slot stream out
// master: the scheduler side (drives s_TREADY, m_TDATA, m_TVALID)
// slave:  the environment side (drives s_TDATA, s_TVALID, m_TREADY)
interface omni_slot_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ*600-1:0] s_TDATA;
  logic [NUM_REQ-1:0]     s_TVALID;
  logic [NUM_REQ-1:0]     s_TREADY;
  logic [599:0]           m_TDATA;
  logic                   m_TVALID;
  logic                   m_TREADY;
  modport master (input s_TDATA, s_TVALID, m_TREADY, output s_TREADY, m_TDATA, m_TVALID);
  modport slave  (output s_TDATA, s_TVALID, m_TREADY, input s_TREADY, m_TDATA, m_TVALID);
endinterface

// File: rtl/omni_slot_sched.sv
// omni_slot_sched: bursts NUM_REQ requester streams onto one 600-bit slot stream, injecting soft-reset headers
// Ports: clk, rst (async, active-low), cfg_start/cfg_num_workers/cfg_busy (header injection),
//        grant_id (current or last grant), bus (s_* requester side, m_* slot side).
// OMNI_SCHED_RR_EN defined: round-robin arbitration; undefined: fixed priority, lowest index wins.
module omni_slot_sched #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 16,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [29:0]      cfg_num_workers,
  output logic             cfg_busy,
  output logic [ID_W-1:0]  grant_id,
  omni_slot_sched_if.master bus
);
  localparam logic [1:0] INIT = 2'd0, HDR = 2'd1, ARB = 2'd2, XFER = 2'd3;
  localparam logic [7:0] LAST = 8'(BURST_LEN - 1);
  logic [1:0]      state;
  logic [7:0]      cnt;
  logic            pend, hdr_out, m_valid;
  logic [599:0]    m_data;
  logic [ID_W-1:0] sel;
  logic            out_free, start_acc, accept, hdr_load, burst_end;
  assign out_free  = !m_valid || bus.m_TREADY;
  assign start_acc = cfg_start && !cfg_busy;
  assign accept    = state == XFER && out_free && bus.s_TVALID[grant_id];
  assign hdr_load  = state == HDR && out_free;
  assign burst_end = (accept && cnt == LAST) || (out_free && !bus.s_TVALID[grant_id]);
  assign bus.s_TREADY = (state == XFER && out_free) ? NUM_REQ'(1) << grant_id : '0;
  assign bus.m_TDATA  = m_data;
  assign bus.m_TVALID = m_valid;
`ifdef OMNI_SCHED_RR_EN
  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] rot;
  // valid vector rotated so bit 0 is the requester at the pointer; lowest set bit wins
  always_comb begin
    rot = NUM_REQ'({bus.s_TVALID, bus.s_TVALID} >> ptr);
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) sel = (int'(ptr) + k >= NUM_REQ) ? ID_W'(int'(ptr) + k - NUM_REQ) : ID_W'(int'(ptr) + k);
  end
`else
  always_comb begin
    sel = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.s_TVALID[k]) sel = ID_W'(k);
  end
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      cnt      <= '0;
      pend     <= 1'b0;
      hdr_out  <= 1'b0;
      cfg_busy <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      grant_id <= '0;
`ifdef OMNI_SCHED_RR_EN
      ptr      <= '0;
`endif
    end else begin
      // hdr_out marks that the output register holds the header, so busy drops only on its acceptance
      cfg_busy <= start_acc || (cfg_busy && !(m_valid && bus.m_TREADY && hdr_out));
      pend     <= start_acc || (pend && !hdr_load);
      hdr_out  <= hdr_load || (hdr_out && !(m_valid && bus.m_TREADY));
      if (hdr_load || accept) begin
        m_valid <= 1'b1;
        m_data  <= hdr_load ? {568'b0, cfg_num_workers, 2'b01} : bus.s_TDATA[600*grant_id +: 600];
      end else if (bus.m_TREADY) m_valid <= 1'b0;
      case (state)
        INIT: if (start_acc) state <= HDR;
        HDR:  if (out_free) state <= ARB;
        ARB:
          if (pend || start_acc) state <= HDR;
          else if (|bus.s_TVALID) begin
            grant_id <= sel;
            cnt      <= '0;
            state    <= XFER;
`ifdef OMNI_SCHED_RR_EN
            ptr      <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
`endif
          end
        XFER: begin
          if (accept) cnt <= cnt + 8'd1;
          if (burst_end) state <= ARB;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_omni_slot_sched.sv
// tb_omni_slot_sched: randomized self-checking bench with a behavioural reference model
module tb_omni_slot_sched;
  localparam int N  = 4;
  localparam int BL = 4;
`ifdef OMNI_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, cfg_start = 1'b0, cfg_busy;
  logic [29:0] cfg_num_workers = '0;
  logic [1:0]  grant_id;
  omni_slot_sched_if #(.NUM_REQ(N)) bus ();
  omni_slot_sched #(.NUM_REQ(N), .BURST_LEN(BL), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_workers(cfg_num_workers),
    .cfg_busy(cfg_busy), .grant_id(grant_id), .bus(bus));
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  // reference model: phase 0 unconfigured, 1 header due, 2 choosing, 3 serving a burst
  int ph, mg, used, mptr, n_sacc = 0, n_hdr = 0;
  logic e_mv, e_busy, e_pend, e_hdr;
  logic [599:0] e_md;
  logic [1:0] e_gid;
  logic [N-1:0] e_srdy, s_acc_next = '0;
  logic [599:0] fifo[$];
  int acc_log[$];
  // stimulus state
  int rmode = 0;
  logic rrdy = 1'b0;
  logic [N-1:0] vmask = '0, vld = '0;
  logic [599:0] sw [N];
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, act, exp); end
  endtask
  task automatic chkw(string nm, logic [599:0] act, logic [599:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %h expected %h", nm, act, exp); end
  endtask
  function automatic int pick(logic [N-1:0] v, int from);
    for (int k = 0; k < N; k++) begin
      int idx = (from + k) % N;
      if (v[2'(idx)]) return idx;
    end
    return 0;
  endfunction
  function automatic logic [599:0] rnd600();
    logic [599:0] w = '0;
    for (int j = 0; j < 19; j++) w = {w[567:0], 32'($urandom())};
    return w;
  endfunction
  task automatic model_reset();
    ph = 0; mg = 0; used = 0; mptr = 0;
    e_mv = 1'b0; e_busy = 1'b0; e_pend = 1'b0; e_hdr = 1'b0; e_md = '0; e_gid = '0;
    fifo.delete();
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) bus.s_TDATA[600*i +: 600] = sw[i];
    bus.s_TVALID = vld;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (s_acc_next[i]) sw[i] = rnd600();
      if (rmode == 0) vld[i] = vmask[i];
      else if (s_acc_next[i] || !vld[i]) vld[i] = ($urandom_range(0, 2) != 0);
    end
    bus.m_TREADY = rrdy ? 1'($urandom_range(0, 1)) : 1'b1;
    drive();
  endtask
  always @(negedge clk) begin : mdl
    logic free, take, hdr_ld, hdr_done;
    logic [N-1:0] sv, sacc;
    logic [599:0] w;
    int nph;
    if (!rst) model_reset();
    free = !e_mv || bus.m_TREADY;
    e_srdy = (ph == 3 && free) ? N'(1 << mg) : '0;
    chk("s_TREADY", 64'(bus.s_TREADY), 64'(e_srdy));
    chk("m_TVALID", 64'(bus.m_TVALID), 64'(e_mv));
    if (e_mv) chkw("m_TDATA", bus.m_TDATA, e_md);
    chk("cfg_busy", 64'(cfg_busy), 64'(e_busy));
    chk("grant_id", 64'(grant_id), 64'(e_gid));
    s_acc_next = bus.s_TVALID & bus.s_TREADY;
    for (int i = 0; i < N; i++) if (s_acc_next[i]) begin acc_log.push_back(i); n_sacc++; end
    if (rst) begin
      sv = bus.s_TVALID;
      take = cfg_start && !e_busy;
      sacc = e_srdy & sv;
      hdr_ld = ph == 1 && free;
      hdr_done = e_mv && bus.m_TREADY && e_hdr;
      // every requester word must leave in the order it was taken
      if (e_mv && bus.m_TREADY && !e_hdr) begin
        w = (fifo.size() > 0) ? fifo.pop_front() : 'x;
        chkw("out_order", bus.m_TDATA, w);
      end
      if (sacc != 0) fifo.push_back(bus.s_TDATA[600*mg +: 600]);
      nph = ph;
      case (ph)
        0: if (take) nph = 1;
        1: if (free) nph = 2;
        2: if (e_pend || take) nph = 1;
           else if (sv != 0) begin
             mg = pick(sv, RR ? mptr : 0);
             mptr = (mg + 1) % N;
             e_gid = 2'(mg);
             used = 0;
             nph = 3;
           end
        default: begin
          if (sacc != 0) used++;
          if ((sacc != 0 && used == BL) || (free && !sv[2'(mg)])) nph = 2;
        end
      endcase
      ph = nph;
      if (take) e_busy = 1'b1;
      else if (hdr_done) e_busy = 1'b0;
      if (take) e_pend = 1'b1;
      if (hdr_ld) e_pend = 1'b0;
      if (hdr_ld) begin
        e_md = {568'b0, cfg_num_workers, 2'b01}; e_mv = 1'b1; e_hdr = 1'b1; n_hdr++;
      end else if (sacc != 0) begin
        e_md = bus.s_TDATA[600*mg +: 600]; e_mv = 1'b1; e_hdr = 1'b0;
      end else if (bus.m_TREADY) begin
        e_mv = 1'b0; e_hdr = 1'b0;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int base, hb;
    model_reset();
    for (int i = 0; i < N; i++) sw[i] = rnd600();
    bus.m_TREADY = 1'b1;
    drive();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_TVALID", 64'(bus.m_TVALID), 0);
    chk("rst_s_TREADY", 64'(bus.s_TREADY), 0);
    chk("rst_cfg_busy", 64'(cfg_busy), 0);
    chk("rst_grant_id", 64'(grant_id), 0);
    chkw("rst_m_TDATA", bus.m_TDATA, '0);
    rst = 1'b1;
    vmask = 4'b1111;
    repeat (50) tick();
    chk("idle_accepts", 64'(n_sacc), 0);
    chk("idle_m_TVALID", 64'(bus.m_TVALID), 0);
    cfg_num_workers = 30'd5;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tick();
    chk("hdr_valid", 64'(bus.m_TVALID), 1);
    chk("hdr_low", 64'(bus.m_TDATA[31:0]), 64'h15);
    chk("hdr_high_zero", 64'(|bus.m_TDATA[599:32]), 0);
    chk("hdr_busy", 64'(cfg_busy), 1);
    tick();
    chk("hdr_busy_drop", 64'(cfg_busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    vmask = 4'b0011;
    tick();
    tick();
    rst = 1'b1;
    acc_log.delete();
    cfg_num_workers = 30'd3;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int c = 0; c < 200 && acc_log.size() < 16; c++) tick();
    chk("alt_count", 64'(acc_log.size() >= 16), 1);
    for (int k = 0; k < 16 && k < acc_log.size(); k++)
      chk($sformatf("grant_seq%0d", k), 64'(acc_log[k]), RR ? 64'((k / 4) % 2) : 64'(0));
    for (int c = 0; c < 100 && !(ph == 3 && used == 2); c++) tick();
    base = n_sacc;
    hb = n_hdr;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int c = 0; c < 50 && n_hdr == hb; c++) tick();
    chk("mid_words_before_hdr", 64'(n_sacc - base), 2);
    chk("mid_busy", 64'(cfg_busy), 1);
    rmode = 1;
    rrdy = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cfg_start = ($urandom_range(0, 120) == 0);
      cfg_num_workers = 30'($urandom());
      if (c == 1500) begin
        cfg_start = 1'b0;
        for (int k = 0; k < 200 && ph != 3; k++) tick();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_m_TVALID", 64'(bus.m_TVALID), 0);
        chk("arst_s_TREADY", 64'(bus.s_TREADY), 0);
        chk("arst_cfg_busy", 64'(cfg_busy), 0);
        chkw("arst_m_TDATA", bus.m_TDATA, '0);
        tick();
        rst = 1'b1;
        cfg_start = 1'b1;
      end
      tick();
    end
    rmode = 0;
    vmask = '0;
    rrdy = 1'b0;
    cfg_start = 1'b0;
    repeat (30) tick();
    chk("drain_fifo", 64'(fifo.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/omni_slot_sched.md
# omni_slot_sched

Front-end scheduler for the top-k omni slot datapath. It shares the slot's single 600-bit input stream between `NUM_REQ` upstream requesters, granting bursts of up to `BURST_LEN` words per requester. It also sequences slot configuration: it injects the soft-reset header word carrying `num_workers` before any payload traffic, and again on request. Its output drives the slot's `rx_TDATA`/`rx_TVALID`/`rx_TREADY` directly.

## Interface
- `NUM_REQ`, 4: number of requester streams, 2..8.
- `BURST_LEN`, 16: maximum consecutive words per grant, 1..255.
- `ID_W`, 2: grant id width, equal to clog2(`NUM_REQ`).
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `cfg_start` in 1: one-cycle pulse requesting injection of a soft-reset header.
- `cfg_num_workers` in 30: worker count placed in the reset header; sampled on the cycle the header is loaded.
- `cfg_busy` out 1: high from `cfg_start` acceptance until the header word is accepted downstream.
- `s_TDATA` in `NUM_REQ`*600: requester i occupies bits [600*i+599:600*i].
- `s_TVALID` in `NUM_REQ`: per-requester valid.
- `s_TREADY` out `NUM_REQ`: per-requester ready; at most one bit high.
- `m_TDATA` out 600: to slot; layout {metadata[599:512], payload[511:32], header[31:0]}.
- `m_TVALID` out 1: to slot.
- `m_TREADY` in 1: from slot.
- `grant_id` out `ID_W`: index of the current or last granted requester.

## Operation
- States are INIT, HDR, ARB and XFER.
- The output register (`m_TDATA`/`m_TVALID`) is a single stage. It may load when `!m_TVALID | m_TREADY`; this condition is called `out_free`.
- **INIT** (reset state): all `s_TREADY`=0; no payload is accepted.
  - `cfg_start` -> HDR.
  - Without a first header, the slot's worker count is undefined, so INIT is left only via `cfg_start`.
- **HDR**: when `out_free`, load the header word:
  - `m_TDATA` = {88'b0, 480'b0, `cfg_num_workers`, 1'b0, 1'b1}.
  - `m_TVALID`=1.
  - Next state: ARB.
  - `cfg_busy` falls when that word is accepted (`m_TVALID & m_TREADY`).
- **ARB**: one cycle.
  - If a requester is pending, select it, set `grant_id`, clear the burst counter, go to XFER.
  - If no requester is valid, stay in ARB.
  - A pending `cfg_start` has priority over requesters: go to HDR.
- **XFER**:
  - `s_TREADY[grant_id]` = `out_free`.
  - On accept (`s_TVALID[g] & s_TREADY[g]`): copy `s_TDATA` slice g to `m_TDATA`, set `m_TVALID`=1, increment the burst counter.
  - The burst ends, and the block goes to ARB next cycle, in either case:
    - an accept occurs with counter = `BURST_LEN`-1; or
    - `out_free`=1 and `s_TVALID[g]`=0 (requester idle).
- **`cfg_start` outside INIT**: sets a pending flag; `cfg_busy`=1 immediately.
  - The header is injected at the next burst boundary; the current burst is never split.
  - `cfg_start` while pending is ignored; the header uses `cfg_num_workers` at load time.
- Data passes unmodified; the block never inspects requester headers.

## Timing
- Reset values: `m_TVALID`=0, `m_TDATA`=0, `s_TREADY`=0, `cfg_busy`=0, `grant_id`=0, state INIT, pending flag 0, round-robin pointer 0.
- Latency: requester accept to `m_TVALID` is 1 cycle.
- Grant switch overhead is 1 bubble cycle (ARB).
- Steady-state throughput is one word per cycle within a burst while `m_TREADY`=1.
- `m_TVALID`/`m_TDATA` hold stable while `m_TVALID & !m_TREADY`.
- `s_TREADY` is combinational from state, `grant_id` and `out_free`.
- `cfg_start` pulse to header `m_TVALID`:
  - 2 cycles from INIT or ARB.
  - Otherwise the burst remainder plus 2 cycles.
- Reset asserted mid-burst: everything clears asynchronously, including any word in the output register; no partial state survives.

## Configuration
- `OMNI_SCHED_RR_EN` defined: round-robin. ARB searches from pointer `p` upward modulo `NUM_REQ`; on grant of g, `p` = g+1 mod `NUM_REQ`.
- Not defined: fixed priority. The lowest valid index wins and there is no pointer register; requester 0 can starve the others.

## Test plan
- Reset, then hold `s_TVALID`=4'b1111 with no `cfg_start` -> `s_TREADY` stays 0 and `m_TVALID` stays 0 for 50 cycles.
- `cfg_start` with `cfg_num_workers`=5 -> 2 cycles later `m_TDATA[31:0]`=32'h15, upper bits 0, `m_TVALID`=1; `cfg_busy` drops after the accept.
- `BURST_LEN`=4, `s_TVALID`=4'b0011 continuously, `m_TREADY`=1, RR enabled -> grants alternate 0,1,0,1 with 4 words each and one bubble between bursts.
- Same stimulus with the macro undefined -> requester 0 is granted every burst; requester 1 is never served.
- `cfg_start` after word 1 of a 4-word burst -> words 2-3 complete, then the header word, then ARB; `cfg_busy` is high throughout.
- `m_TREADY` toggled randomly 50% during bursts -> no word lost or duplicated; `m_TDATA` stable while stalled; order per requester preserved.
